// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Definitions shared by the read and write sides of the asynchronous FIFO:
//   FIFO_ADDR_WIDTH  default address width (depth 2**FIFO_ADDR_WIDTH)
//   FIFO_PTR_WIDTH   pointer width, one wrap bit above the address
//   fifo_ptr_t       pointer type at the default width
//   bin2gray()       binary -> reflected Gray code
//   gray2bin()       reflected Gray code -> binary
// -----------------------------------------------------------------------------
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int FIFO_PTR_WIDTH  = FIFO_ADDR_WIDTH + 1;

    typedef logic [FIFO_PTR_WIDTH-1:0] fifo_ptr_t;

    function automatic fifo_ptr_t bin2gray(input fifo_ptr_t bin);
        return (bin >> 1) ^ bin;
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic fifo_ptr_t gray2bin(input fifo_ptr_t gray);
        fifo_ptr_t bin;
        bin = '0;
        for (int i = 0; i < FIFO_PTR_WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
        return bin;
    endfunction

endpackage : fifo_pkg

// File: rtl/rptr_empty_if.sv
// -----------------------------------------------------------------------------
// rptr_empty_if
// Read-side pointer bundle of the asynchronous FIFO.
//   rinc          read request for this cycle
//   rq2_wptr      Gray write pointer, already synchronized into rclk
//   raddr         binary read address to the FIFO memory
//   rptr          registered Gray read pointer to the write-side synchronizer
//   rempty        registered empty flag
//   ralmost_empty registered rlevel <= threshold flag
//   rlevel        registered fill level seen from the read side
//   runderflow    sticky read-while-empty error flag
// Modports: master drives requests and the synced pointer, slave is the
// pointer/flag logic.
// -----------------------------------------------------------------------------
interface rptr_empty_if #(
    parameter int ADDR_WIDTH = fifo_pkg::FIFO_ADDR_WIDTH
);
    logic                  rinc;
    logic [ADDR_WIDTH:0]   rq2_wptr;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [ADDR_WIDTH:0]   rptr;
    logic                  rempty;
    logic                  ralmost_empty;
    logic [ADDR_WIDTH:0]   rlevel;
    logic                  runderflow;

    modport master (
        output rinc, rq2_wptr,
        input  raddr, rptr, rempty, ralmost_empty, rlevel, runderflow
    );

    modport slave (
        input  rinc, rq2_wptr,
        output raddr, rptr, rempty, ralmost_empty, rlevel, runderflow
    );
endinterface : rptr_empty_if

// File: rtl/gray2bin.sv
// -----------------------------------------------------------------------------
// gray2bin
// Purely combinational Gray-to-binary converter of parameterized width.
//   gray_i  Gray-coded input
//   bin_o   binary equivalent
// -----------------------------------------------------------------------------
module gray2bin #(
    parameter int WIDTH = fifo_pkg::FIFO_PTR_WIDTH
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // NOTE: every bit of bin_o is assigned on every pass, so no latch results.
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule : gray2bin

// File: rtl/rptr_empty.sv
// -----------------------------------------------------------------------------
// rptr_empty
// Read-pointer and empty/level logic of an asynchronous FIFO.
//   rclk  read-domain clock, all state updates on its rising edge
//   rrst  synchronous active-high reset
//   bus   rptr_empty_if slave: rinc, rq2_wptr in; raddr, rptr, rempty,
//         ralmost_empty, rlevel, runderflow out
// Flags and level are computed from the next pointer value, so a read of the
// last word raises rempty on the very next cycle with no bubble.
// -----------------------------------------------------------------------------
module rptr_empty
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = FIFO_ADDR_WIDTH,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic         rclk,
    input  logic         rrst,
    rptr_empty_if.slave  bus
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] THRESH = AEMPTY_THRESH[PW-1:0];

    logic [PW-1:0] rbin_q,   rbin_d;
    logic [PW-1:0] rptr_q,   rgray_d;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          rempty_q, rempty_d;
    logic          raempty_q, raempty_d;
    logic          runderflow_q, runderflow_d;
    logic          raccept;
    logic [PW-1:0] wbin;

    gray2bin #(.WIDTH(PW)) u_wptr_g2b (
        .gray_i (bus.rq2_wptr),
        .bin_o  (wbin)
    );

    // A read is only taken when the registered flag says data is present;
    // a request against an empty FIFO is dropped and latched as underflow.
    assign raccept      = bus.rinc & ~rempty_q;
    assign rbin_d       = rbin_q + {{(PW-1){1'b0}}, raccept};
    assign rgray_d      = (rbin_d >> 1) ^ rbin_d;
    // Modulo subtraction: the wrap bit makes a full FIFO read as 2**ADDR_WIDTH.
    assign rlevel_d     = wbin - rbin_d;
    assign rempty_d     = (rgray_d == bus.rq2_wptr);
    assign raempty_d    = (rlevel_d <= THRESH);
    assign runderflow_d = runderflow_q | (bus.rinc & rempty_q);

    // NOTE: non-blocking assignments keep every register sampling the
    //       pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q       <= '0;
            rptr_q       <= '0;
            rempty_q     <= 1'b1;
            raempty_q    <= 1'b1;
            rlevel_q     <= '0;
            runderflow_q <= 1'b0;
        end else begin
            rbin_q       <= rbin_d;
            rptr_q       <= rgray_d;
            rempty_q     <= rempty_d;
            raempty_q    <= raempty_d;
            rlevel_q     <= rlevel_d;
            runderflow_q <= runderflow_d;
        end
    end

    assign bus.raddr         = rbin_q[ADDR_WIDTH-1:0];
    assign bus.rptr          = rptr_q;
    assign bus.rempty        = rempty_q;
    assign bus.ralmost_empty = raempty_q;
    assign bus.rlevel        = rlevel_q;
    assign bus.runderflow    = runderflow_q;

endmodule : rptr_empty

// File: tb/tb_rptr_empty.sv
// -----------------------------------------------------------------------------
// tb_rptr_empty
// Directed self-checking bench for rptr_empty (ADDR_WIDTH=4, AEMPTY_THRESH=2).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, well away from the active edge.
// -----------------------------------------------------------------------------
module tb_rptr_empty;

    localparam int AW = 4;
    localparam int PW = AW + 1;

    logic rclk = 1'b0;
    logic rrst;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 rclk = ~rclk;

    rptr_empty_if #(.ADDR_WIDTH(AW)) bus ();

    rptr_empty #(.ADDR_WIDTH(AW), .AEMPTY_THRESH(2)) dut (
        .rclk (rclk),
        .rrst (rrst),
        .bus  (bus.slave)
    );

    function automatic logic [PW-1:0] gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b);
        return (v >> 1) ^ v;
    endfunction

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic chk(input string name, input int actual, input int expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        rrst         = 1'b1;
        bus.rinc     = 1'b1;
        bus.rq2_wptr = '0;
        tick();
        tick();
        rrst     = 1'b0;
        bus.rinc = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        chk("reset rptr",          int'(bus.rptr), 0);
        chk("reset raddr",         int'(bus.raddr), 0);
        chk("reset rempty",        int'(bus.rempty), 1);
        chk("reset ralmost_empty", int'(bus.ralmost_empty), 1);
        chk("reset rlevel",        int'(bus.rlevel), 0);
        chk("reset runderflow",    int'(bus.runderflow), 0);
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= 5; i++) begin
            bus.rq2_wptr = gray(i);
            tick();
            chk("fill rlevel", int'(bus.rlevel), i);
            chk("fill rempty", int'(bus.rempty), 0);
            chk("fill ralmost_empty", int'(bus.ralmost_empty), (i <= 2) ? 1 : 0);
        end
        bus.rinc = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("drain raddr", int'(bus.raddr), k);
            tick();
            chk("drain rlevel", int'(bus.rlevel), 4 - k);
            chk("drain ralmost_empty", int'(bus.ralmost_empty), ((4 - k) <= 2) ? 1 : 0);
            chk("drain rempty", int'(bus.rempty), (k == 4) ? 1 : 0);
        end
        bus.rinc = 1'b0;
    endtask

    task automatic test_underflow();
        chk("uf pre runderflow", int'(bus.runderflow), 0);
        bus.rinc = 1'b1;
        tick();
        bus.rinc = 1'b0;
        chk("uf rptr held", int'(bus.rptr), int'(gray(5)));
        chk("uf raddr held", int'(bus.raddr), 5);
        chk("uf runderflow", int'(bus.runderflow), 1);
        bus.rq2_wptr = gray(7);
        tick();
        tick();
        chk("uf sticky", int'(bus.runderflow), 1);
        chk("uf rlevel", int'(bus.rlevel), 2);
    endtask

    task automatic test_full_level();
        do_reset();
        chk("full reset clears runderflow", int'(bus.runderflow), 0);
        bus.rq2_wptr = gray(16);
        tick();
        chk("full rlevel", int'(bus.rlevel), 16);
        chk("full rempty", int'(bus.rempty), 0);
        chk("full ralmost_empty", int'(bus.ralmost_empty), 0);
    endtask

    task automatic test_wrap();
        logic [PW-1:0] prev;
        do_reset();
        bus.rq2_wptr = gray(3);
        tick();
        chk("wrap start rlevel", int'(bus.rlevel), 3);
        prev = bus.rptr;
        for (int i = 0; i < 40; i++) begin
            bus.rinc     = 1'b1;
            bus.rq2_wptr = gray((i + 4) % 32);
            tick();
            chk("wrap rptr", int'(bus.rptr), int'(gray((i + 1) % 32)));
            chk("wrap raddr", int'(bus.raddr), (i + 1) % 16);
            chk("wrap one-bit step", $countones(prev ^ bus.rptr), 1);
            chk("wrap rlevel", int'(bus.rlevel), 3);
            chk("wrap rempty", int'(bus.rempty), 0);
            prev = bus.rptr;
        end
        bus.rinc = 1'b0;
    endtask

    task automatic test_simultaneous();
        // rbin = 40 mod 32 = 8, write pointer at binary 43 (level 3)
        bus.rinc = 1'b1;
        tick();
        tick();
        bus.rinc = 1'b0;
        chk("simul pre rlevel", int'(bus.rlevel), 1);
        chk("simul pre raddr", int'(bus.raddr), 10);
        bus.rinc     = 1'b1;
        bus.rq2_wptr = gray(44 % 32);
        tick();
        bus.rinc = 1'b0;
        chk("simul rlevel", int'(bus.rlevel), 1);
        chk("simul rempty", int'(bus.rempty), 0);
        chk("simul raddr", int'(bus.raddr), 11);
        chk("simul runderflow", int'(bus.runderflow), 0);
    endtask

    task automatic test_reset_priority();
        // Reset while a read and a pointer change are both pending.
        bus.rinc     = 1'b1;
        bus.rq2_wptr = gray(20);
        rrst         = 1'b1;
        tick();
        chk("rstprio rptr", int'(bus.rptr), 0);
        chk("rstprio rempty", int'(bus.rempty), 1);
        chk("rstprio rlevel", int'(bus.rlevel), 0);
        rrst     = 1'b0;
        bus.rinc = 1'b0;
        tick();
        chk("rstprio resume rlevel", int'(bus.rlevel), 20);
        chk("rstprio resume rempty", int'(bus.rempty), 0);
    endtask

    initial begin
        rrst         = 1'b1;
        bus.rinc     = 1'b0;
        bus.rq2_wptr = '0;
        test_reset();
        test_fill_drain();
        test_underflow();
        test_full_level();
        test_wrap();
        test_simultaneous();
        test_reset_priority();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_rptr_empty
